rr_arbiter5: RTL and testbench
==============================

# rr_arbiter5

Five-way round-robin arbiter that shares a single resource (e.g. one KCPSM3 output port or a shared peripheral strobe) among five requesters. Each requester holds a level request; the arbiter issues a registered one-hot grant, holds it until the owner releases or a hold-limit timer expires, inserts one dead cycle, then rotates priority. Its "any request pending" term is the 5-input OR (NAND of inverted inputs) of the request lines. It sits between the requesting sequencers and the shared resource's enable/select logic.

## Interface
- HOLD_MAX, 16: maximum consecutive grant cycles per ownership; 0 disables the limit; legal range 0..255
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- req  in  5  level request per requester, bit i = requester i
- gnt  out  5  registered one-hot grant; all-zero when no owner
- gnt_id  out  3  binary index of current owner 0..4; 3'b111 when no owner
- busy  out  1  high in GRANT and GAP states
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- State is one of IDLE, GRANT or GAP. Internal registers: ptr (0..4, next-highest-priority index), owner (0..4), cnt (8 bits).
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, … modulo 5 (4 wraps to 0). any_req = OR of req[4:0].
- IDLE: gnt=0. At the edge, if any_req=1: owner←winner, cnt←0, go to GRANT. Otherwise stay in IDLE.
- GRANT: gnt has bit owner set. At each edge:
  - req[owner]=0: release, go to GAP.
  - Else if HOLD_MAX≠0 and cnt=HOLD_MAX−1: forced release, go to GAP, timeout←1 for the GAP cycle.
  - Else cnt←cnt+1.
  - Requests from other requesters never preempt the owner.
- On any release, ptr←(owner+1) mod 5, so the revoked owner gets lowest priority in the next arbitration.
- GAP: gnt=0 for exactly one cycle. At the edge, if any_req=1, select the winner with the updated ptr and go to GRANT; else go to IDLE.
- The arbiter never drives gnt with more than one bit set and never re-grants without the GAP cycle.

## Timing
- Reset (synchronous, takes effect at the first clk edge with reset=1) forces state=IDLE, ptr=0, owner=0, cnt=0, gnt=5'b0, gnt_id=3'b111, busy=0, timeout=0.
- Reset has priority over all other activity, including mid-grant: gnt drops at the reset edge, with no GAP cycle and no timeout pulse.
- Grant latency: req rising is sampled at edge k while in IDLE; gnt is high from edge k. This is one cycle after the requester drives req, registered.
- Release latency: req[owner] seen low at edge k; gnt is low from edge k.
- Forced hold: gnt is high for exactly HOLD_MAX cycles. timeout is high during the following GAP cycle only.
- gnt_id and busy are registered and change on the same edges as gnt.
- req sampled at the release edge does not affect the release. The next winner is chosen at the GAP exit edge from req at that edge.
- Owner dropping req at the very edge where cnt=HOLD_MAX−1: treat it as a normal release, with no timeout.

## Test plan
- Reset with req=5'b11111 held: outputs are gnt=0, gnt_id=7, busy=0, timeout=0. At the first edge after reset deasserts, gnt=5'b00001 and gnt_id=0.
- HOLD_MAX=4, req=5'b11111 constant: grants go 0,1,2,3,4,0. Each grant is high 4 cycles, followed by 1 low GAP cycle with timeout=1, and timeout is never asserted during a grant.
- Single requester req=5'b00100 pulsed for 3 cycles: gnt=5'b00100 for 3 cycles starting at the first edge it is seen. Then one GAP cycle with busy=1, then IDLE with busy=0 and gnt_id=7.
- Wrap and fairness: owner 4 releases while req=5'b10001, and the next grant is 0. Owner 1 releases and re-requests immediately with req[3]=1 pending, and the next grant is 3, not 1.
- HOLD_MAX=0, req[2] held 300 cycles: gnt stays 5'b00100 the whole time with timeout=0. A concurrent req[0] is not granted until req[2] drops.
- Reset asserted mid-grant (owner 3, cnt=2): gnt=0 and gnt_id=7 at the reset edge with no timeout. After reset, with req=5'b01000, the first grant is 3 (ptr=0 scan reaches it).

Source files
------------

// File: rtl/rr_arbiter5.sv
// rr_arbiter5: five-way round-robin arbiter with hold limit.
// One-hot registered grant, one dead cycle between owners.
module rr_arbiter5 #(
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] req,
   output logic [4:0] gnt,
   output logic [2:0] gnt_id,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
   localparam bit         LIMIT_EN  = (HOLD_MAX != 0);

   state_t     state_q;
   logic [2:0] ptr_q;
   logic [2:0] owner_q;
   logic [7:0] cnt_q;
   logic [4:0] gnt_q;
   logic [2:0] gnt_id_q;
   logic       busy_q;
   logic       timeout_q;

   logic       any_req;
   logic [2:0] win;
   logic       found;
   logic [3:0] idx;
   logic [2:0] ptr_d;

   // Pending-request term: NAND of the inverted request lines.
   assign any_req = ~&(~req);

   // Rotating scan from ptr; the first asserted request wins.
   always_comb begin
      win   = ptr_q;
      found = 1'b0;
      idx   = 4'd0;
      for (int i = 0; i < 5; i++) begin
         idx = {1'b0, ptr_q} + 4'(i);
         if (idx >= 4'd5) idx = idx - 4'd5;
         if (!found && req[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end
      end
   end

   // After a release the old owner drops to lowest priority.
   assign ptr_d = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd0;
         owner_q   <= 3'd0;
         cnt_q     <= 8'd0;
         gnt_q     <= 5'd0;
         gnt_id_q  <= 3'b111;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         unique case (state_q)
            IDLE, GAP: begin
               if (any_req) begin
                  state_q  <= GRANT;
                  owner_q  <= win;
                  cnt_q    <= 8'd0;
                  gnt_q    <= 5'd1 << win;
                  gnt_id_q <= win;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= IDLE;
                  gnt_q    <= 5'd0;
                  gnt_id_q <= 3'b111;
                  busy_q   <= 1'b0;
               end
            end
            GRANT: begin
               if (!req[owner_q]) begin
                  state_q  <= GAP;
                  ptr_q    <= ptr_d;
                  gnt_q    <= 5'd0;
                  gnt_id_q <= 3'b111;
               end else if (LIMIT_EN && cnt_q == HOLD_LAST) begin
                  state_q   <= GAP;
                  ptr_q     <= ptr_d;
                  gnt_q     <= 5'd0;
                  gnt_id_q  <= 3'b111;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter5.sv
// tb_rr_arbiter5: directed scenarios plus randomized run
// against a behavioural model, for HOLD_MAX=4 and HOLD_MAX=0.
module tb_rr_arbiter5;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] req;
   logic [4:0] gnt4, gnt0;
   logic [2:0] gid4, gid0;
   logic       busy4, busy0, to4, to0;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rr_arbiter5 #(.HOLD_MAX(4)) dut4 (
      .clk(clk), .reset(reset), .req(req),
      .gnt(gnt4), .gnt_id(gid4), .busy(busy4), .timeout(to4)
   );

   rr_arbiter5 #(.HOLD_MAX(0)) dut0 (
      .clk(clk), .reset(reset), .req(req),
      .gnt(gnt0), .gnt_id(gid0), .busy(busy0), .timeout(to0)
   );

   // Model: owner (-1 = none), cycles held so far, gap flag.
   typedef struct packed {
      int own;
      bit gap;
      int ptr;
      int held;
      bit to;
   } mst_t;

   mst_t m4, m0;

   function automatic mst_t mstep(mst_t s, logic [4:0] r,
                                  logic rst, int h);
      mst_t n = s;
      n.to = 1'b0;
      if (rst) begin
         n.own = -1; n.gap = 1'b0; n.ptr = 0; n.held = 0;
         return n;
      end
      if (s.own >= 0) begin
         if (!r[s.own] || (h != 0 && s.held == h)) begin
            n.to  = r[s.own];
            n.ptr = (s.own + 1) % 5;
            n.own = -1;
            n.gap = 1'b1;
         end else begin
            n.held = s.held + 1;
         end
      end else begin
         n.gap = 1'b0;
         for (int k = 0; k < 5; k++) begin
            if (r[(s.ptr + k) % 5]) begin
               n.own  = (s.ptr + k) % 5;
               n.held = 1;
               break;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [9:0] mout(mst_t s);
      logic [4:0] g;
      logic [2:0] id;
      logic       b;
      g  = (s.own >= 0) ? 5'(1 << s.own) : 5'd0;
      id = (s.own >= 0) ? 3'(s.own) : 3'd7;
      b  = (s.own >= 0) || s.gap;
      return {g, id, b, s.to};
   endfunction

   always @(posedge clk) begin
      m4 = mstep(m4, req, reset, 4);
      m0 = mstep(m0, req, reset, 0);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 5'd0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 5'b11111;
      tick();
      tick();
      n_vec++;
      if ({gnt4, gid4, busy4, to4} !== {5'd0, 3'd7, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_outs got=%b exp=%b",
                  {gnt4, gid4, busy4, to4}, {5'd0, 3'd7, 2'b00});
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if ({gnt4, gid4} !== {5'b00001, 3'd0}) begin
         n_bad++;
         $display("FAIL reset_first_gnt got=%b/%0d exp=00001/0",
                  gnt4, gid4);
      end
   endtask

   task automatic test_rotation();
      logic [4:0] eg;
      logic       et;
      do_reset();
      req = 5'b11111;
      for (int c = 0; c < 30; c++) begin
         tick();
         eg = ((c % 5) < 4) ? 5'(1 << ((c / 5) % 5)) : 5'd0;
         et = ((c % 5) == 4);
         n_vec++;
         if (gnt4 !== eg || to4 !== et) begin
            n_bad++;
            $display("FAIL rotation c=%0d got=%b/%b exp=%b/%b",
                     c, gnt4, to4, eg, et);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      tick();
      req = 5'b00100;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_vec++;
         if (gnt4 !== 5'b00100 || gid4 !== 3'd2) begin
            n_bad++;
            $display("FAIL single_gnt c=%0d got=%b exp=00100", c, gnt4);
         end
      end
      req = 5'd0;
      tick();
      n_vec++;
      if ({gnt4, gid4, busy4, to4} !== {5'd0, 3'd7, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL single_gap got=%b exp=0000011110",
                  {gnt4, gid4, busy4, to4});
      end
      tick();
      n_vec++;
      if ({gnt4, gid4, busy4} !== {5'd0, 3'd7, 1'b0}) begin
         n_bad++;
         $display("FAIL single_idle got=%b exp=000001110",
                  {gnt4, gid4, busy4});
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 5'b10000;
      tick();
      n_vec++;
      if (gnt4 !== 5'b10000) begin
         n_bad++;
         $display("FAIL wrap_own4 got=%b exp=10000", gnt4);
      end
      req = 5'b00001;
      tick();
      req = 5'b10001;
      tick();
      n_vec++;
      if (gnt4 !== 5'b00001 || gid4 !== 3'd0) begin
         n_bad++;
         $display("FAIL wrap_next got=%b exp=00001", gnt4);
      end
      do_reset();
      req = 5'b00010;
      tick();
      n_vec++;
      if (gnt4 !== 5'b00010) begin
         n_bad++;
         $display("FAIL fair_own1 got=%b exp=00010", gnt4);
      end
      req = 5'b01000;
      tick();
      req = 5'b01010;
      tick();
      n_vec++;
      if (gnt4 !== 5'b01000 || gid4 !== 3'd3) begin
         n_bad++;
         $display("FAIL fair_next got=%b exp=01000", gnt4);
      end
   endtask

   task automatic test_nolimit();
      do_reset();
      req = 5'b00100;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (c == 5) req = 5'b00101;
         n_vec++;
         if (gnt0 !== 5'b00100 || to0 !== 1'b0) begin
            n_bad++;
            $display("FAIL nolimit c=%0d got=%b/%b exp=00100/0",
                     c, gnt0, to0);
         end
      end
      req = 5'b00001;
      tick();
      n_vec++;
      if (gnt0 !== 5'd0 || busy0 !== 1'b1) begin
         n_bad++;
         $display("FAIL nolimit_gap got=%b/%b exp=00000/1", gnt0, busy0);
      end
      tick();
      n_vec++;
      if (gnt0 !== 5'b00001) begin
         n_bad++;
         $display("FAIL nolimit_next got=%b exp=00001", gnt0);
      end
   endtask

   task automatic test_reset_midgrant();
      do_reset();
      req = 5'b01000;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      n_vec++;
      if ({gnt4, gid4, busy4, to4} !== {5'd0, 3'd7, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL midreset got=%b exp=0000011100",
                  {gnt4, gid4, busy4, to4});
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if (gnt4 !== 5'b01000 || gid4 !== 3'd3) begin
         n_bad++;
         $display("FAIL midreset_regrant got=%b/%0d exp=01000/3",
                  gnt4, gid4);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0)
            req = 5'($urandom_range(0, 31));
         reset = ($urandom_range(0, 199) == 0);
         tick();
         n_vec++;
         if ({gnt4, gid4, busy4, to4} !== mout(m4)) begin
            n_bad++;
            $display("FAIL random_h4 c=%0d got=%b exp=%b",
                     c, {gnt4, gid4, busy4, to4}, mout(m4));
         end
         n_vec++;
         if ({gnt0, gid0, busy0, to0} !== mout(m0)) begin
            n_bad++;
            $display("FAIL random_h0 c=%0d got=%b exp=%b",
                     c, {gnt0, gid0, busy0, to0}, mout(m0));
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 5'd0;
      @(negedge clk);
      test_reset();
      test_rotation();
      test_single();
      test_wrap();
      test_nolimit();
      test_reset_midgrant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
